cla_4bit_adder: RTL and testbench
=================================

// Module: cla_4bit_adder
// PURPOSE
//   4-bit carry-lookahead adder slice with registered outputs.
//   Computes S = A + B + Cin and the group propagate/generate terms PG/GG, so
//   instances can be cascaded under a second-level lookahead unit in the datapath ALU.
//   Sum logic is combinational lookahead (no ripple); results are captured in output registers.
// PARAMETERS
//   none (width fixed at 4 bits)
// PORTS
//   clk       input   1  rising-edge clock; single clock domain
//   rst_n     input   1  asynchronous, active-low reset
//   in_valid  input   1  A/B/Cin are valid this cycle; capture result
//   A         input   4  operand A (unsigned / two's complement, same bits)
//   B         input   4  operand B
//   Cin       input   1  carry in
//   S         output  4  registered sum bits
//   Cout      output  1  registered carry out (C4)
//   PG        output  1  registered group propagate
//   GG        output  1  registered group generate
//   out_valid output  1  S/Cout/PG/GG hold a newly captured result
// BEHAVIOUR
//   Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   Reset: rst_n=0 immediately forces S=4'b0000, Cout=0, PG=0, GG=0, out_valid=0,
//     independent of clk; outputs stay there until the first capture after release.
//   Per bit i=0..3: Pi = Ai ^ Bi, Gi = Ai & Bi.
//   Carries (flattened lookahead, no chained Ci terms):
//     C0=Cin; C1=G0|P0C0; C2=G1|P1G0|P1P0C0; C3=G2|P2G1|P2P1G0|P2P1P0C0;
//     C4=G3|P3G2|P3P2G1|P3P2P1G0|P3P2P1P0C0.
//   Si = Pi ^ Ci; Cout = C4.
//   PG = P3&P2&P1&P0; GG = G3|P3G2|P3P2G1|P3P2P1G0. PG/GG do not depend on Cin.
//   Capture: on rising clk with in_valid=1, register S, Cout, PG, GG from the
//     current A/B/Cin; set out_valid=1. Latency: 1 cycle.
//   in_valid=0 at a rising edge: S/Cout/PG/GG hold their previous values;
//     out_valid=0 for that cycle.
//   Back-to-back in_valid: one result per cycle; no stall, no backpressure.
//   Overflow: carry-out only, no wrap flag; 1111+1111+1 -> S=1111, Cout=1.
//   Reset asserted mid-stream: outputs clear at once and the in-flight result is lost;
//     the first in_valid after release yields valid output on the next edge.
//   Invariant: {Cout,S} == A + B + Cin for every captured vector.
// TESTING
//   Reset: rst_n=0 with nonzero inputs -> S=0000 Cout=0 PG=0 GG=0 out_valid=0, no clk needed.
//   A=0001 B=0000 Cin=0 -> next edge S=0001 Cout=0 PG=0 GG=0 out_valid=1;
//     A=0100 B=0011 Cin=0 -> S=0111 Cout=0 PG=0 GG=0.
//   A=1101 B=1010 Cin=1 -> S=1000 Cout=1 PG=0 GG=1;
//     A=1110 B=1001 Cin=0 -> S=0111 Cout=1 PG=0 GG=1.
//   A=1111 B=1010 Cin=0 -> S=1001 Cout=1 PG=0 GG=1;
//     A=1010 B=0101 Cin=1 -> S=0000 Cout=1 PG=1 GG=0 (full propagate chain).
//   Hold and valid: in_valid=0 with changed inputs -> outputs unchanged, out_valid=0;
//     assert rst_n low between two valid vectors -> outputs clear asynchronously.
//   Exhaustive: all 512 {A,B,Cin} vectors, back-to-back -> {Cout,S}==A+B+Cin;
//     PG/GG match the formulas one cycle later.

Source files
------------

// File: rtl/cla_4bit_adder.sv
// 4-bit carry-lookahead adder slice with registered sum, carry-out and group P/G.
// Group terms let several slices sit under a second-level lookahead unit.
module cla_4bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       PG,
    output logic       GG,
    output logic       out_valid
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] s_next;
    logic       pg_next;
    logic       gg_next;

    assign p = A ^ B;
    assign g = A & B;

    // Each carry is a flat sum-of-products of P/G and Cin, so no carry waits on another.
    assign c[0] = Cin;
    assign c[1] = g[0]
                | (p[0] & c[0]);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_next = p ^ c[3:0];

    // Group terms are independent of Cin so an upper lookahead level can use them directly.
    assign pg_next = p[3] & p[2] & p[1] & p[0];
    assign gg_next = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);

    // Handshake: in_valid=1 at a rising edge captures one result, presented the
    // following cycle with out_valid=1 for exactly that cycle. There is no ready;
    // the slice accepts a new vector every cycle. With in_valid=0 the result
    // registers hold and out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= 4'b0000;
            Cout      <= 1'b0;
            PG        <= 1'b0;
            GG        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= s_next;
                Cout <= c[4];
                PG   <= pg_next;
                GG   <= gg_next;
            end
        end
    end

endmodule

// File: tb/tb_cla_4bit_adder.sv
// Directed and exhaustive checks of cla_4bit_adder against hand-computed and arithmetic expectations.
module tb_cla_4bit_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       PG;
    logic       GG;
    logic       out_valid;

    int errors;
    int checks;

    cla_4bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .PG        (PG),
        .GG        (GG),
        .out_valid (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {out_valid, GG, PG, Cout, S}
    function automatic logic [7:0] observed();
        return {out_valid, GG, PG, Cout, S};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got {ov,GG,PG,Cout,S}=%b_%b_%b_%b_%04b expected %b_%b_%b_%b_%04b",
                     tag, obs[7], obs[6], obs[5], obs[4], obs[3:0],
                     exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Drive one vector with in_valid high, check the registered result after the edge.
    task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic [7:0] exp);
        @(negedge clk);
        A = a; B = b; Cin = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check(tag, observed(), exp);
    endtask

    logic [4:0] sum;
    logic       exp_pg;
    logic       exp_gg;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        A = 4'b1011; B = 4'b0110; Cin = 1'b1;

        // Reset with nonzero inputs, before any clock edge matters
        #1;
        check("reset_initial", observed(), 8'b0_0_0_0_0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_clocked", observed(), 8'b0_0_0_0_0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", observed(), 8'b0_0_0_0_0000);

        // Directed vectors, expected {ov,GG,PG,Cout,S}
        apply("a1_b0",        4'b0001, 4'b0000, 1'b0, 8'b1_0_0_0_0001);
        apply("a4_b3",        4'b0100, 4'b0011, 1'b0, 8'b1_0_0_0_0111);
        apply("d_a_cin",      4'b1101, 4'b1010, 1'b1, 8'b1_1_0_1_1000);
        apply("e_9",          4'b1110, 4'b1001, 1'b0, 8'b1_1_0_1_0111);
        apply("f_a",          4'b1111, 4'b1010, 1'b0, 8'b1_1_0_1_1001);
        apply("full_prop",    4'b1010, 4'b0101, 1'b1, 8'b1_0_1_1_0000);
        apply("max_overflow", 4'b1111, 4'b1111, 1'b1, 8'b1_1_0_1_1111);
        apply("prop_no_cin",  4'b1010, 4'b0101, 1'b0, 8'b1_0_1_0_1111);
        apply("zero",         4'b0000, 4'b0000, 1'b0, 8'b1_0_0_0_0000);

        // Hold: in_valid low with changed inputs keeps last result, out_valid drops
        @(negedge clk);
        in_valid = 1'b0;
        A = 4'b0111; B = 4'b0111; Cin = 1'b1;
        @(posedge clk);
        #1;
        check("hold_1", observed(), 8'b0_0_0_0_0000);
        apply("after_hold",   4'b0011, 4'b0101, 1'b0, 8'b1_0_0_0_1000);
        @(negedge clk);
        in_valid = 1'b0;
        A = 4'b1111; B = 4'b1111; Cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hold_2", observed(), 8'b0_0_0_0_1000);

        // Reset mid-stream: valid vector in flight, reset clears asynchronously
        apply("pre_reset",    4'b1101, 4'b1010, 1'b1, 8'b1_1_0_1_1000);
        @(negedge clk);
        A = 4'b1111; B = 4'b0001; Cin = 1'b0; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", observed(), 8'b0_0_0_0_0000);
        @(posedge clk);
        #1;
        check("reset_held", observed(), 8'b0_0_0_0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", observed(), 8'b0_0_0_0_0000);
        apply("post_reset",   4'b1110, 4'b1001, 1'b0, 8'b1_1_0_1_0111);

        // Exhaustive back-to-back: every {A,B,Cin}, checked one cycle after drive
        for (int v = 0; v < 512; v++) begin
            @(negedge clk);
            A = v[8:5]; B = v[4:1]; Cin = v[0];
            in_valid = 1'b1;
            sum    = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
            exp_pg = (({1'b0, A} + {1'b0, B}) == 5'd15);
            exp_gg = (({1'b0, A} + {1'b0, B}) > 5'd15);
            exp_q.push_back({1'b1, exp_gg, exp_pg, sum});
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            check("exhaustive", observed(), exp_v);
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_idle_ov", {7'b0, out_valid}, 8'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
